// File: rtl/board_io_if.sv
// board_io_if: pin and GPIO bundle between FPGA pins, SoC core and board_io_ctrl
interface board_io_if #(
  parameter int N_BTN = 1,
  parameter int N_SW  = 16,
  parameter int N_LED = 16,
  parameter int PWM_W = 8
);
  logic             pll_locked_i;
  logic [N_BTN-1:0] btn_i;
  logic [N_SW-1:0]  sw_i;
  logic [N_BTN-1:0] btn_o;
  logic [N_BTN-1:0] btn_rise_o;
  logic [N_SW-1:0]  sw_o;
  logic [N_LED-1:0] led_i;
  logic [1:0]       led_mode_i;
  logic [PWM_W-1:0] pwm_duty_i;
  logic [N_LED-1:0] led_o;
  logic             core_rst_o;
  modport slave (
    input  pll_locked_i, btn_i, sw_i, led_i, led_mode_i, pwm_duty_i,
    output btn_o, btn_rise_o, sw_o, led_o, core_rst_o
  );
  modport master (
    output pll_locked_i, btn_i, sw_i, led_i, led_mode_i, pwm_duty_i,
    input  btn_o, btn_rise_o, sw_o, led_o, core_rst_o
  );
endinterface

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: PLL-lock reset sequencer, button/switch debounce and LED mode driver
module board_io_ctrl #(
  parameter int N_BTN      = 1,
  parameter int N_SW       = 16,
  parameter int N_LED      = 16,
  parameter int DEB_CYCLES = 50000,
  parameter int RST_HOLD   = 1024,
  parameter int PWM_W      = 8,
  parameter int BLINK_DIV  = 24
) (
  input logic       clk_i,
  input logic       rst_i,
  board_io_if.slave io
);
  localparam int N_CH = N_BTN + N_SW;
  localparam int CW   = $clog2(DEB_CYCLES + 1);
  localparam int HW   = $clog2(RST_HOLD + 1);
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;
  state_t               state, state_nx;
  logic                 lock_m, lock_s, core_rst;
  logic [HW-1:0]        hold_cnt;
  logic [N_CH-1:0]      raw_m, raw_s, stable, accept;
  logic [N_BTN-1:0]     btn_rise;
  logic [PWM_W-1:0]     pwm_cnt;
  logic [BLINK_DIV-1:0] presc;
  logic [N_LED-1:0]     led_q, led_nx;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_m   <= 1'b0;
      lock_s   <= 1'b0;
      state    <= WAIT_LOCK;
      hold_cnt <= '0;
      core_rst <= 1'b1;
    end else begin
      lock_m   <= io.pll_locked_i;
      lock_s   <= lock_m;
      state    <= state_nx;
      hold_cnt <= state == HOLD ? hold_cnt + HW'(1) : '0;
      core_rst <= state_nx != RUN;
    end
  end
  // lock loss wins over the terminal count
  always_comb begin
    state_nx = state;
    if (!lock_s) state_nx = WAIT_LOCK;
    else if (state == WAIT_LOCK) state_nx = HOLD;
    else if (state == HOLD && hold_cnt == HW'(RST_HOLD - 1)) state_nx = RUN;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_m    <= '0;
      raw_s    <= '0;
      stable   <= '0;
      btn_rise <= '0;
    end else begin
      raw_m    <= {io.sw_i, io.btn_i};
      raw_s    <= raw_m;
      stable   <= stable ^ accept;
      btn_rise <= accept[N_BTN-1:0] & raw_s[N_BTN-1:0];
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_deb
    logic [CW-1:0] cnt;
    assign accept[i] = raw_s[i] != stable[i] && cnt == CW'(DEB_CYCLES - 1);
    always_ff @(posedge clk_i)
      if (rst_i || raw_s[i] == stable[i] || accept[i]) cnt <= '0;
      else cnt <= cnt + CW'(1);
  end
  always_comb begin
    led_nx = core_rst                 ? '0 :
             io.led_mode_i == 2'b00   ? io.led_i :
             io.led_mode_i == 2'b01   ? io.led_i & {N_LED{pwm_cnt < io.pwm_duty_i}} :
             io.led_mode_i == 2'b10   ? io.led_i & {N_LED{presc[BLINK_DIV-1]}} : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt <= '0;
      presc   <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      presc   <= presc + BLINK_DIV'(1);
      led_q   <= led_nx;
    end
  end
  assign io.btn_o      = stable[N_BTN-1:0];
  assign io.sw_o       = stable[N_CH-1:N_BTN];
  assign io.btn_rise_o = btn_rise;
  assign io.led_o      = led_q;
  assign io.core_rst_o = core_rst;
endmodule
